// File: rtl/axi_switch_pkg.sv
// Shared types and helpers for the axi_switch per-slave arbiters.
// Helper functions work on MAX_M-wide vectors; callers cast to their own width.
package axi_switch_pkg;

   localparam int unsigned MAX_M     = 32;
   localparam int unsigned MAX_LOG_M = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } wr_arb_state_t;

   // One-hot grant for the first set bit at or above ptr, wrapping modulo m (ptr < m).
   function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0]     req,
                                                input logic [MAX_LOG_M-1:0] ptr,
                                                input int unsigned          m);
      logic [MAX_M-1:0] gnt;
      logic             found;
      int unsigned      idx;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_M; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= m) idx = idx - m;
         if (i < m && !found && req[idx[MAX_LOG_M-1:0]]) begin
            gnt[idx[MAX_LOG_M-1:0]] = 1'b1;
            found                   = 1'b1;
         end
      end
      return gnt;
   endfunction

   function automatic logic [MAX_LOG_M-1:0] onehot2bin(input logic [MAX_M-1:0] oh);
      logic [MAX_LOG_M-1:0] bin;
      bin = '0;
      for (int unsigned i = 0; i < MAX_M; i++) begin
         if (oh[i]) bin = bin | MAX_LOG_M'(i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/axi_wr_slave_arbiter_if.sv
// Control bundle between a slave port's write-path glue and its arbiter.
interface axi_wr_slave_arbiter_if #(
   parameter int unsigned M       = 4,
   parameter int unsigned B_DEPTH = 4
);
   localparam int unsigned LOG_M = $clog2(M);
   localparam int unsigned CW    = $clog2(B_DEPTH + 1);

   logic [M-1:0]     aw_req;
   logic             aw_hs;
   logic             w_hs;
   logic             w_last;
   logic             b_hs;
   logic [M-1:0]     aw_gnt;
   logic [LOG_M-1:0] aw_sel;
   logic             aw_gnt_valid;
   logic [LOG_M-1:0] w_sel;
   logic             w_active;
   logic [LOG_M-1:0] b_sel;
   logic             b_valid;
   logic [CW-1:0]    outstanding;

   modport slave (
      input  aw_req, aw_hs, w_hs, w_last, b_hs,
      output aw_gnt, aw_sel, aw_gnt_valid, w_sel, w_active, b_sel, b_valid, outstanding
   );

   modport master (
      output aw_req, aw_hs, w_hs, w_last, b_hs,
      input  aw_gnt, aw_sel, aw_gnt_valid, w_sel, w_active, b_sel, b_valid, outstanding
   );
endinterface

// File: rtl/axi_idx_fifo.sv
// Synchronous index FIFO with occupancy count; head reads as zero when empty.
module axi_idx_fifo #(
   parameter int unsigned W     = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && !full;
   assign dout    = empty ? '0 : mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; the head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/axi_wr_slave_arbiter.sv
// Per-slave write arbiter: round-robin AW grant, W lock until WLAST,
// and in-order B routing through a queue of accepted master indices.
module axi_wr_slave_arbiter
   import axi_switch_pkg::*;
#(
   parameter int unsigned M       = 4,
   parameter int unsigned B_DEPTH = 4
) (
   input logic                    clk,
   input logic                    rstn,
   axi_wr_slave_arbiter_if.slave  bus
);
   localparam int unsigned LOG_M = $clog2(M);

   wr_arb_state_t    state, state_n;
   logic [M-1:0]     gnt_q, gnt_n;
   logic [LOG_M-1:0] sel_q, sel_n;
   logic [LOG_M-1:0] wsel_q, wsel_n;
   logic [LOG_M-1:0] rr_q, rr_n;
   logic             gv_q, wa_q;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         gnt_q  <= '0;
         sel_q  <= '0;
         wsel_q <= '0;
         rr_q   <= '0;
         gv_q   <= 1'b0;
         wa_q   <= 1'b0;
      end else begin
         state  <= state_n;
         gnt_q  <= gnt_n;
         sel_q  <= sel_n;
         wsel_q <= wsel_n;
         rr_q   <= rr_n;
         gv_q   <= (state_n == ADDR);
         wa_q   <= (state_n == DATA);
      end
   end

   // A new grant needs a free B slot so the push in ADDR can never overflow.
   always_comb begin
      state_n   = state;
      gnt_n     = gnt_q;
      sel_n     = sel_q;
      wsel_n    = wsel_q;
      rr_n      = rr_q;
      fifo_push = 1'b0;
      unique case (state)
         IDLE: begin
            if ((|bus.aw_req) && !fifo_full) begin
               gnt_n   = M'(rr_pick(MAX_M'(bus.aw_req), MAX_LOG_M'(rr_q), M));
               sel_n   = LOG_M'(onehot2bin(MAX_M'(gnt_n)));
               state_n = ADDR;
            end
         end
         ADDR: begin
            if (bus.aw_hs) begin
               fifo_push = 1'b1;
               wsel_n    = sel_q;
               gnt_n     = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (bus.w_hs && bus.w_last) begin
               rr_n    = (wsel_q == LOG_M'(M - 1)) ? '0 : wsel_q + LOG_M'(1);
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   axi_idx_fifo #(
      .W     (LOG_M),
      .DEPTH (B_DEPTH)
   ) u_b_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .din   (sel_q),
      .pop   (bus.b_hs),
      .dout  (bus.b_sel),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (bus.outstanding)
   );

   assign bus.aw_gnt       = gnt_q;
   assign bus.aw_sel       = sel_q;
   assign bus.aw_gnt_valid = gv_q;
   assign bus.w_sel        = wsel_q;
   assign bus.w_active     = wa_q;
   assign bus.b_valid      = !fifo_empty;
endmodule

// File: doc/axi_wr_slave_arbiter.md
Name: axi_wr_slave_arbiter

Overview:
- Per-slave write-path controller for the axi_switch crossbar; one instance per slave port (N instances).
- Arbitrates AW requests from M masters targeting this slave, using round-robin.
- Locks the W channel to the granted master until WLAST.
- Queues granted master indices so B responses route back in AW-acceptance order.

Parameters:
- M, 4, number of masters.
- LOG_M, $clog2(M), width of a master index.
- B_DEPTH, 4, max outstanding writes (AW accepted, B not yet returned) for this slave; power of two, >= 1.

Ports:
- clk  input  1  switch clock.
- rstn  input  1  asynchronous active-low reset.
- aw_req  input  M  bit i = master i AWVALID with address decoded to this slave.
- aw_hs  input  1  AWVALID&AWREADY at the slave-side AW port.
- w_hs  input  1  WVALID&WREADY at the slave-side W port.
- w_last  input  1  WLAST at the slave-side W port.
- b_hs  input  1  BVALID&BREADY at the slave-side B port.
- aw_gnt  output  M  one-hot AW grant; drives the AW mux and AWREADY gating.
- aw_sel  output  LOG_M  binary index of the granted master.
- aw_gnt_valid  output  1  AW grant active.
- w_sel  output  LOG_M  master index whose W channel is routed to this slave.
- w_active  output  1  W routing enabled.
- b_sel  output  LOG_M  master index that owns the oldest outstanding B.
- b_valid  output  1  at least one B outstanding.
- outstanding  output  $clog2(B_DEPTH+1)  count of outstanding writes.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, rr_ptr=0, FIFO empty. Outputs: aw_gnt=0, aw_sel=0, aw_gnt_valid=0, w_sel=0, w_active=0, b_sel=0, b_valid=0, outstanding=0. Reset mid-burst discards the grant and all queued B indices; no completion is emitted.
- FSM states:
  - IDLE:
    - If aw_req!=0 and outstanding<B_DEPTH, pick the first set bit searching from rr_ptr upward modulo M.
    - Register the choice into aw_gnt/aw_sel and go to ADDR.
    - The grant is visible the cycle after the request: 1-cycle latency.
    - If outstanding==B_DEPTH, stay in IDLE with no grant.
  - ADDR:
    - aw_gnt_valid=1; grant held stable.
    - Changes in aw_req are ignored (AXI requires AWVALID to stay high).
    - On aw_hs: push aw_sel into the B FIFO, latch w_sel=aw_sel, go to DATA.
    - aw_gnt and aw_gnt_valid are 0 from the next cycle.
  - DATA:
    - w_active=1.
    - On w_hs&w_last: go to IDLE and set rr_ptr=(w_sel+1) mod M.
    - w_hs without w_last stays in DATA.
    - w_active drops the cycle after the last beat.
- w_hs/w_last outside DATA are ignored; W routing is never enabled before AW acceptance.
- Minimum spacing between consecutive grants: IDLE→ADDR→DATA→IDLE, so one idle bubble per burst.
- B FIFO:
  - Depth B_DEPTH; push on aw_hs in ADDR; pop on b_hs when b_valid.
  - b_sel = head entry; b_valid = !empty.
  - outstanding = occupancy.
  - Simultaneous push and pop: occupancy unchanged, ordering preserved.
  - Pop when empty is ignored.
  - Push when full is impossible by construction: grant requires outstanding<B_DEPTH, and occupancy cannot rise before the push.
- Pointers wrap modulo B_DEPTH; rr_ptr wraps modulo M.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.

Decomposition:
- Shared package axi_switch_pkg, containing:
  - the wr_arb_state_t enum {IDLE, ADDR, DATA};
  - the function rr_pick(req, ptr), returning a one-hot grant, reused by the read-side arbiter;
  - the function onehot2bin.
- One natural sub-module: axi_idx_fifo (parameterised width/depth, synchronous FIFO with count), also reusable for R-channel ordering.

Test Plan:
- Reset check: hold rstn=0 for 10 cycles with aw_req=4'b1111 → all outputs 0. Release → aw_gnt=4'b0001, aw_sel=0 one cycle later.
- Round-robin: aw_req=4'b1111 held. Run 4 bursts (aw_hs, then one w_hs with w_last=1) → grant sequence masters 0,1,2,3,0. After each grant, b_sel order is 0,1,2,3.
- W lock: grant master 2, aw_hs, then 8 beats with w_last only on beat 8. Drive w_hs/w_last during ADDR beforehand → those are ignored. w_active=1 and w_sel=2 throughout the burst; IDLE one cycle after beat 8.
- Outstanding limit: B_DEPTH=4, no b_hs, complete 4 bursts → outstanding=4, no further grant despite aw_req=4'b0100. One b_hs → outstanding=3, grant to master 2 on the next cycle.
- Simultaneous events: at outstanding=2, aw_hs and b_hs in the same cycle → outstanding stays 2, head advances, new index appended at tail.
- Mid-burst reset: assert rstn=0 while in DATA with 3 outstanding → w_active, b_valid and outstanding=0 immediately (asynchronous). After release, arbitration restarts from master 0.
